// File: rtl/register_snapshot_reader_pkg.sv
// ============================================================================
//  Module   : register_snapshot_reader_pkg
//  Brief    : Shared constants and helpers for the snapshot reader.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package register_snapshot_reader_pkg;

    localparam int OVF_W = 8;

    localparam logic [OVF_W-1:0] c_OVF_MAX = '1;

    function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] i_val);
        return (i_val == c_OVF_MAX) ? i_val : i_val + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/register_snapshot_reader_if.sv
// ============================================================================
//  Module   : register_snapshot_reader_if
//  Brief    : valid/ready snapshot stream between the reader and its consumer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface register_snapshot_reader_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

`default_nettype wire

// File: rtl/register_snapshot_reader_snapshot_fifo.sv
// ============================================================================
//  Module   : snapshot_fifo
//  Brief    : DEPTH-entry FIFO with level tracking; storage is not reset.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module snapshot_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     i_push,
    input  wire logic                     i_pop,
    input  wire logic [WIDTH-1:0]         i_data,
    output logic      [WIDTH-1:0]         o_data,
    output logic      [$clog2(DEPTH):0]   o_level,
    output logic                          o_full,
    output logic                          o_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    logic w_wr_en;
    logic w_rd_en;

    assign o_full  = (r_level == LVL_W'(DEPTH));
    assign o_empty = (r_level == '0);

    // A write into a full FIFO is only legal when the head leaves the same cycle.
    assign w_wr_en = i_push & (~o_full | i_pop);
    assign w_rd_en = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr_en && !w_rd_en) begin
                r_level <= r_level + LVL_W'(1);
            end else if (!w_wr_en && w_rd_en) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_level = r_level;

endmodule

`default_nettype wire

// File: rtl/register_snapshot_reader.sv
// ============================================================================
//  Module   : register_snapshot_reader
//  Brief    : Streams every change (or forced sample) of a watched register.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module register_snapshot_reader
    import register_snapshot_reader_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] INITIAL = '0
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic [WIDTH-1:0]         i_value,
    input  wire logic                     i_sample_req,
    register_snapshot_reader_if.master    snap,
    output logic      [$clog2(DEPTH):0]   o_level,
    output logic      [OVF_W-1:0]         o_overflow_count
);
    logic [WIDTH-1:0] r_shadow;
    logic [OVF_W-1:0] r_ovf_cnt;

    logic             w_ev;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_full;
    logic             w_empty;
    logic [WIDTH-1:0] w_head;

    assign w_ev   = (i_value != r_shadow) | i_sample_req;
    assign w_pop  = snap.valid & snap.ready;
    assign w_push = w_ev & (~w_full | w_pop);
    assign w_drop = w_ev & w_full & ~w_pop;

    snapshot_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (i_value),
        .o_data  (w_head),
        .o_level (o_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Shadow follows every event, stored or dropped, so a drop never re-fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow  <= INITIAL;
            r_ovf_cnt <= '0;
        end else begin
            if (w_ev) begin
                r_shadow <= i_value;
            end
            if (w_drop) begin
                r_ovf_cnt <= sat_inc(r_ovf_cnt);
            end
        end
    end

    assign snap.valid       = ~w_empty;
    assign snap.data        = w_head;
    assign o_overflow_count = r_ovf_cnt;

endmodule

`default_nettype wire

// File: tb/tb_register_snapshot_reader.sv
// ============================================================================
//  Module   : tb_register_snapshot_reader
//  Brief    : Scoreboard bench for register_snapshot_reader (WIDTH 32, DEPTH 4).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_register_snapshot_reader;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam logic [WIDTH-1:0] INIT = '0;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] value = 32'd5;
    logic             sample_req = 1'b0;
    logic [2:0]       level;
    logic [7:0]       ovf;

    register_snapshot_reader_if #(.WIDTH(WIDTH)) snap ();

    register_snapshot_reader #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .INITIAL (INIT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_value          (value),
        .i_sample_req     (sample_req),
        .snap             (snap.master),
        .o_level          (level),
        .o_overflow_count (ovf)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: contents of the buffer, last seen value, drop count.
    logic [WIDTH-1:0] m_q   [$];
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] m_shadow;
    int               m_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            exp_q.delete();
            m_shadow = INIT;
            m_ovf    = 0;
        end else begin
            bit m_pop;
            bit m_ev;
            m_pop = (m_q.size() != 0) && snap.ready;
            m_ev  = (value != m_shadow) || sample_req;
            if (m_pop) void'(m_q.pop_front());
            if (m_ev) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back(value);
                    exp_q.push_back(value);
                end else if (m_ovf < 255) begin
                    m_ovf++;
                end
                m_shadow = value;
            end
        end
    end

    // Monitor: inputs for the next edge are settled, outputs are stable.
    initial forever begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            chk("out_valid", snap.valid, (m_q.size() != 0));
            chk("level", level, m_q.size());
            chk("overflow_count", ovf, m_ovf);
            if (snap.valid && snap.ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", 1, 0);
                end else begin
                    chk("out_data", snap.data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic drive(input logic [WIDTH-1:0] v, input logic s, input logic r);
        @(negedge clk);
        value      = v;
        sample_req = s;
        snap.ready = r;
    endtask

    task automatic drain(input logic [WIDTH-1:0] v);
        int budget = 0;
        drive(v, 1'b0, 1'b1);
        while (m_q.size() != 0 && budget < 50) begin
            drive(v, 1'b0, 1'b1);
            budget++;
        end
        drive(v, 1'b0, 1'b1);
        chk("drain_timeout", (budget >= 50), 0);
    endtask

    initial begin
        snap.ready = 1'b0;
        // 1: reset with a nonzero value, release onto INITIAL -> nothing emitted
        repeat (3) @(negedge clk);
        value = '0;
        rst_n = 1'b1;
        repeat (10) drive('0, 1'b0, 1'b1);
        chk("idle_level", level, 0);

        // 2: single change streamed straight through
        drive(32'd7, 1'b0, 1'b1);
        repeat (3) drive(32'd7, 1'b0, 1'b1);
        chk("single_level", level, 0);

        // 3: fill with ready low, two drops, then drain in order
        for (int i = 1; i <= 6; i++) drive(i, 1'b0, 1'b0);
        drive(32'd6, 1'b0, 1'b0);
        #2;
        chk("full_level", level, 4);
        chk("full_ovf", ovf, 2);

        // 4: full FIFO, ready high, change every cycle
        for (int i = 10; i < 20; i++) drive(i, 1'b0, 1'b1);
        #2;
        chk("stream_level", level, 4);
        chk("stream_ovf", ovf, 2);
        drain(32'd19);

        // 5: forced samples of an unchanged value
        drive(32'd9, 1'b0, 1'b0);
        drive(32'd9, 1'b1, 1'b0);
        drive(32'd9, 1'b1, 1'b0);
        drive(32'd9, 1'b0, 1'b0);
        drive(32'd9, 1'b0, 1'b0);
        #2;
        chk("sample_level", level, 3);
        drain(32'd9);

        // 6: three entries buffered, short asynchronous reset mid-cycle
        for (int i = 21; i <= 23; i++) drive(i, 1'b0, 1'b0);
        drive('0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", snap.valid, 0);
        chk("rst_level", level, 0);
        rst_n = 1'b1;
        repeat (3) drive('0, 1'b0, 1'b0);
        #2;
        chk("post_rst_level", level, 0);

        // random traffic
        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 3), ($urandom_range(0, 7) == 0), $urandom_range(0, 1));
        drain(32'd100);

        // 7: overflow counter saturates
        for (int i = 0; i < 270; i++) drive(32'd1000 + i, 1'b0, 1'b0);
        drive(32'd1269, 1'b0, 1'b0);
        #2;
        chk("ovf_sat", ovf, 255);
        drive(32'd5000, 1'b0, 1'b0);
        drive(32'd5000, 1'b0, 1'b0);
        #2;
        chk("ovf_hold", ovf, 255);
        drain(32'd5000);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
